// File: rtl/drum_pkg.sv
// Shared types and constants for the drum grid feedback path.
// All datapath values are signed 1.17 fixed point.
package drum_pkg;

    typedef logic signed [17:0] fix17_t;

    localparam fix17_t RHO_INIT_C = 18'sd6553;
    localparam fix17_t RHO_MAX_C  = 18'sd62914;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } fb_state_t;

endpackage

// File: rtl/drum_grid_feedback_ctrl_if.sv
// Centre-sample stream from the feedback controller to the audio path.
interface drum_grid_feedback_ctrl_if;
    import drum_pkg::*;

    fix17_t sample_data;
    logic   sample_valid;
    logic   sample_ready;

    modport master (
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/drum_sample_fifo.sv
// Sample FIFO between the feedback controller and the audio path.
// A push is taken when there is room or when the head leaves in the same cycle.
module drum_sample_fifo
    import drum_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   clear,
    input  logic   push,
    input  fix17_t push_data,
    output fix17_t out_data,
    output logic   out_valid,
    input  logic   out_ready,
    output logic   full
);

    localparam int             PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    fix17_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             pop;
    logic             push_ok;

    assign out_valid = (count != '0);
    assign full      = (count == FULL_COUNT);
    assign pop       = out_valid && out_ready;
    assign push_ok   = push && (!full || pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Storage is left unreset; the empty-gated output keeps stale entries invisible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/signed_mult_1_17.sv
// Signed 1.17 x 1.17 multiply, result rescaled back to 1.17.
module signed_mult_1_17 (
    input  logic signed [17:0] a,
    input  logic signed [17:0] b,
    output logic signed [17:0] out
);

    logic signed [35:0] product;

    assign product = 36'(a) * 36'(b);
    assign out     = 18'(product >>> 17);

endmodule

// File: rtl/drum_grid_feedback_ctrl.sv
// Closed-loop controller for the drum node grid: seeds the hit, feeds node outputs
// back as neighbour inputs, tracks nonlinear tension and streams centre samples.
module drum_grid_feedback_ctrl
    import drum_pkg::*;
#(
    parameter int     SIZE       = 4,
    parameter int     FIFO_DEPTH = 8,
    parameter fix17_t RHO_INIT   = RHO_INIT_C,
    parameter fix17_t RHO_MAX    = RHO_MAX_C,
    parameter int     RHO_SHIFT  = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  fix17_t      u_hit_mid     [SIZE][SIZE],
    input  fix17_t      u_2_mid       [SIZE][SIZE],
    input  logic        iterFlag,
    output fix17_t      u_2_mid_input [SIZE][SIZE],
    output fix17_t      rho,
    output logic        grid_run,
    drum_grid_feedback_ctrl_if.master sample,
    output logic [15:0] iter_count,
    output logic [7:0]  drop_count
);

    localparam int MID = SIZE >> 1;

    fb_state_t state;
    fb_state_t next_state;
    logic      load_en;
    logic      iter_en;
    logic      pop;
    logic      drop;
    fix17_t    centre;
    fix17_t    sq;
    fix17_t    rho_step;
    fix17_t    fifo_data;
    logic      fifo_valid;
    logic      fifo_full;

    assign centre = u_2_mid[MID][MID];

    signed_mult_1_17 u_square (
        .a   (centre),
        .b   (centre),
        .out (sq)
    );

    assign rho_step = RHO_INIT + (sq >>> RHO_SHIFT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // start outranks stop so a restart request is never lost.
    always_comb begin
        next_state = state;
        load_en    = 1'b0;
        grid_run   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                load_en    = 1'b1;
                next_state = RUN;
            end
            RUN: begin
                grid_run = 1'b1;
                if (start) begin
                    next_state = LOAD;
                end else if (stop) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign iter_en = grid_run && iterFlag;
    assign pop     = fifo_valid && sample.sample_ready;
    assign drop    = iter_en && fifo_full && !pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    u_2_mid_input[i][j] <= '0;
                end
            end
            rho        <= RHO_INIT;
            iter_count <= '0;
            drop_count <= '0;
        end else if (load_en) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    u_2_mid_input[i][j] <= u_hit_mid[i][j];
                end
            end
            rho        <= RHO_INIT;
            iter_count <= '0;
            drop_count <= '0;
        end else if (iter_en) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    u_2_mid_input[i][j] <= u_2_mid[i][j];
                end
            end
            rho        <= (rho < RHO_MAX) ? rho_step : RHO_MAX;
            iter_count <= iter_count + 16'd1;
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

    drum_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (load_en),
        .push      (iter_en),
        .push_data (centre),
        .out_data  (fifo_data),
        .out_valid (fifo_valid),
        .out_ready (sample.sample_ready),
        .full      (fifo_full)
    );

    assign sample.sample_data  = fifo_data;
    assign sample.sample_valid = fifo_valid;

endmodule

// File: tb/tb_drum_grid_feedback_ctrl.sv
// Directed bench for drum_grid_feedback_ctrl; a second instance with no tension shift
// drives rho past the ceiling so the clamp can be observed.
module tb_drum_grid_feedback_ctrl;
    import drum_pkg::*;

    localparam int SIZE = 4;
    localparam int MID  = SIZE >> 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        iterFlag;
    fix17_t      u_hit_mid [SIZE][SIZE];
    fix17_t      u_2_mid   [SIZE][SIZE];
    fix17_t      u_in      [SIZE][SIZE];
    fix17_t      u_in_hi   [SIZE][SIZE];
    fix17_t      rho;
    fix17_t      rho_hi;
    logic        grid_run;
    logic        grid_run_hi;
    logic [15:0] iter_count;
    logic [15:0] iter_count_hi;
    logic [7:0]  drop_count;
    logic [7:0]  drop_count_hi;

    int testsRun    = 0;
    int testsFailed = 0;

    drum_grid_feedback_ctrl_if smp ();
    drum_grid_feedback_ctrl_if smp_hi ();

    assign smp_hi.sample_ready = smp.sample_ready;

    always #5 clock = ~clock;

    drum_grid_feedback_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .u_hit_mid     (u_hit_mid),
        .u_2_mid       (u_2_mid),
        .iterFlag      (iterFlag),
        .u_2_mid_input (u_in),
        .rho           (rho),
        .grid_run      (grid_run),
        .sample        (smp.master),
        .iter_count    (iter_count),
        .drop_count    (drop_count)
    );

    drum_grid_feedback_ctrl #(
        .RHO_SHIFT (0)
    ) dut_hi (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .u_hit_mid     (u_hit_mid),
        .u_2_mid       (u_2_mid),
        .iterFlag      (iterFlag),
        .u_2_mid_input (u_in_hi),
        .rho           (rho_hi),
        .grid_run      (grid_run_hi),
        .sample        (smp_hi.master),
        .iter_count    (iter_count_hi),
        .drop_count    (drop_count_hi)
    );

    task automatic checkOutput(input string tag, input logic signed [63:0] got,
                               input logic signed [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic s_start, input logic s_stop,
                                 input logic s_iter, input fix17_t s_centre);
        start              = s_start;
        stop               = s_stop;
        iterFlag           = s_iter;
        u_2_mid[MID][MID]  = s_centre;
        tick();
        start    = 1'b0;
        stop     = 1'b0;
        iterFlag = 1'b0;
    endtask

    initial begin
        fix17_t drainExp [8];

        reset            = 1'b1;
        start            = 1'b0;
        stop             = 1'b0;
        iterFlag         = 1'b0;
        smp.sample_ready = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                u_hit_mid[i][j] = 18'sh01000;
                u_2_mid[i][j]   = fix17_t'((i * SIZE + j + 1) * 16);
            end
        end

        #12;
        checkOutput("reset rho", rho, 6553);
        checkOutput("reset grid_run", grid_run, 0);
        checkOutput("reset valid", smp.sample_valid, 0);
        checkOutput("reset data", smp.sample_data, 0);
        checkOutput("reset iter", iter_count, 0);
        checkOutput("reset drop", drop_count, 0);
        checkOutput("reset node00", u_in[0][0], 0);
        checkOutput("reset centre", u_in[MID][MID], 0);
        reset = 1'b0;
        tick();

        // Start, LOAD, then RUN with the hit loaded.
        applyStimulus(1'b1, 1'b0, 1'b0, 18'sh0);
        checkOutput("load grid_run", grid_run, 0);
        tick();
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                checkOutput($sformatf("hit node%0d%0d", i, j), u_in[i][j], 4096);
            end
        end
        checkOutput("run rho", rho, 6553);
        checkOutput("run grid_run", grid_run, 1);
        checkOutput("run iter", iter_count, 0);

        // First iteration with centre 0.5.
        applyStimulus(1'b0, 1'b0, 1'b1, 18'sh10000);
        checkOutput("iter1 rho", rho, 7577);
        checkOutput("iter1 rho_hi", rho_hi, 39321);
        checkOutput("iter1 count", iter_count, 1);
        checkOutput("iter1 centre", u_in[MID][MID], 65536);
        checkOutput("iter1 node01", u_in[0][1], 32);
        checkOutput("iter1 node33", u_in[3][3], 256);
        checkOutput("iter1 valid", smp.sample_valid, 1);
        checkOutput("iter1 data", smp.sample_data, 65536);

        // Tension ceiling.
        applyStimulus(1'b0, 1'b0, 1'b1, 18'sh16000);
        checkOutput("big rho", rho, 8489);
        checkOutput("big rho_hi", rho_hi, 68505);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'sh16000);
        checkOutput("clamp rho_hi", rho_hi, 62914);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'sh16000);
        checkOutput("hold rho_hi", rho_hi, 62914);
        checkOutput("hold iter", iter_count, 4);
        checkOutput("stall data", smp.sample_data, 65536);

        // Restart from RUN clears the run state.
        applyStimulus(1'b1, 1'b0, 1'b0, 18'sh0);
        tick();
        checkOutput("restart valid", smp.sample_valid, 0);
        checkOutput("restart iter", iter_count, 0);
        checkOutput("restart rho", rho, 6553);
        checkOutput("restart rho_hi", rho_hi, 6553);
        checkOutput("restart grid_run", grid_run, 1);

        // Ten pushes into an 8-deep FIFO with no consumer.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, fix17_t'(1000 * (k + 1)));
        end
        checkOutput("fill iter", iter_count, 10);
        checkOutput("fill drop", drop_count, 2);
        checkOutput("fill valid", smp.sample_valid, 1);
        checkOutput("fill head", smp.sample_data, 1000);
        checkOutput("fill centre", u_in[MID][MID], 10000);
        checkOutput("fill rho", rho, 6576);

        // Full FIFO, push together with a pop.
        smp.sample_ready = 1'b1;
        checkOutput("head before pop", smp.sample_data, 1000);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'sd12345);
        checkOutput("pushpop drop", drop_count, 2);
        checkOutput("pushpop iter", iter_count, 11);
        checkOutput("pushpop head", smp.sample_data, 2000);

        for (int k = 0; k < 7; k++) begin
            drainExp[k] = fix17_t'(2000 + 1000 * k);
        end
        drainExp[7] = 18'sd12345;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("drain valid%0d", k), smp.sample_valid, 1);
            checkOutput($sformatf("drain data%0d", k), smp.sample_data, drainExp[k]);
            tick();
        end
        checkOutput("drained valid", smp.sample_valid, 0);
        checkOutput("drained data", smp.sample_data, 0);

        // Drop counter saturation.
        smp.sample_ready = 1'b0;
        for (int k = 0; k < 270; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 18'sd7);
        end
        checkOutput("sat drop", drop_count, 255);
        checkOutput("sat iter", iter_count, 281);

        // Stop with a simultaneous iteration, then idle behaviour.
        applyStimulus(1'b0, 1'b1, 1'b1, 18'sd555);
        checkOutput("stop grid_run", grid_run, 0);
        checkOutput("stop iter", iter_count, 282);
        checkOutput("stop centre", u_in[MID][MID], 555);
        applyStimulus(1'b0, 1'b0, 1'b1, 18'sd777);
        checkOutput("idle iter", iter_count, 282);
        checkOutput("idle centre", u_in[MID][MID], 555);
        smp.sample_ready = 1'b1;
        repeat (8) tick();
        checkOutput("idle drain valid", smp.sample_valid, 0);
        checkOutput("idle drop", drop_count, 255);

        // start and stop together while running.
        applyStimulus(1'b1, 1'b0, 1'b0, 18'sh0);
        tick();
        checkOutput("rerun grid_run", grid_run, 1);
        checkOutput("rerun drop", drop_count, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 18'sh0);
        tick();
        checkOutput("start beats stop", grid_run, 1);

        // Asynchronous reset between edges.
        smp.sample_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 18'sh10000);
        checkOutput("pre-reset valid", smp.sample_valid, 1);
        checkOutput("pre-reset iter", iter_count, 1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async grid_run", grid_run, 0);
        checkOutput("async valid", smp.sample_valid, 0);
        checkOutput("async data", smp.sample_data, 0);
        checkOutput("async rho", rho, 6553);
        checkOutput("async iter", iter_count, 0);
        checkOutput("async centre", u_in[MID][MID], 0);
        #2;
        reset = 1'b0;
        tick();
        tick();
        checkOutput("post-reset grid_run", grid_run, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
